// File: rtl/nmu_axi2noc_packet_pkg.sv
// ---------------------------------------------------------------------------
// nmu_pkg
// Shared definitions for the NoC master unit request packetizer:
//   - flit type codes carried in the head flit
//   - fixed head-field widths (offsets that depend on the address and id
//     widths are derived in nmu_head_build)
//   - FSM state encoding of the packetizer
// No ports (package).
// ---------------------------------------------------------------------------
package nmu_pkg;

    localparam logic [2:0] TYPE_WR     = 3'b001;
    localparam logic [2:0] TYPE_RD_REQ = 3'b010;

    // Fixed-width head fields. The head layout, LSB first, is
    // addr | len | seq | final | axi_id | src | dest | type | zero pad.
    localparam int LEN_W   = 8;
    localparam int SEQ_W   = 8;
    localparam int FINAL_W = 1;
    localparam int TYPE_W  = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        W_DATA = 2'd1,
        W_HEAD = 2'd2
    } nmu_state_e;

endpackage

// File: rtl/nmu_axi2noc_packet_if.sv
// ---------------------------------------------------------------------------
// nmu_axi2noc_packet_if
// AXI4 request-side bundle (AW, W, AR channels) between a user master and the
// NoC master unit packetizer.
//   slave  modport : used by the packetizer (valids/payload in, readies out)
//   master modport : used by the user master / testbench
// Signals: s_axi_aw{id,addr,len,valid,ready}, s_axi_w{data,last,valid,ready},
//          s_axi_ar{id,addr,len,valid,ready}
// ---------------------------------------------------------------------------
interface nmu_axi2noc_packet_if #(
    parameter int DATA_WIDTH     = 128,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_ADDR_WIDTH = 32
);
    logic [AXI_ID_WIDTH-1:0]   s_axi_awid;
    logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr;
    logic [7:0]                s_axi_awlen;
    logic                      s_axi_awvalid;
    logic                      s_axi_awready;

    logic [DATA_WIDTH-1:0]     s_axi_wdata;
    logic                      s_axi_wlast;
    logic                      s_axi_wvalid;
    logic                      s_axi_wready;

    logic [AXI_ID_WIDTH-1:0]   s_axi_arid;
    logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr;
    logic [7:0]                s_axi_arlen;
    logic                      s_axi_arvalid;
    logic                      s_axi_arready;

    modport slave (
        input  s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awvalid,
        output s_axi_awready,
        input  s_axi_wdata, s_axi_wlast, s_axi_wvalid,
        output s_axi_wready,
        input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arvalid,
        output s_axi_arready
    );

    modport master (
        output s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awvalid,
        input  s_axi_awready,
        output s_axi_wdata, s_axi_wlast, s_axi_wvalid,
        input  s_axi_wready,
        output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arvalid,
        input  s_axi_arready
    );
endinterface

// File: rtl/nmu_axi2noc_packet_head_build.sv
// ---------------------------------------------------------------------------
// nmu_head_build
// Combinational head-flit formatter shared by the AR, AW and follow-on write
// head paths of the packetizer.
// Ports:
//   addr      in  AXI_ADDR_WIDTH  packet start address (dest = addr MSBs)
//   len       in  8               beats-1 carried by this packet / request
//   seq       in  8               packet sequence number within a burst
//   final_pkt in  1               last packet of the burst
//   axi_id    in  AXI_ID_WIDTH    AXI transaction id
//   pkt_type  in  3               TYPE_WR / TYPE_RD_REQ
//   flit      out DATA_WIDTH+1    head flit, valid bit (MSB) set
// DATA_WIDTH must be >= AXI_ADDR_WIDTH + 2*ID_WIDTH + AXI_ID_WIDTH + 20.
// ---------------------------------------------------------------------------
module nmu_head_build
    import nmu_pkg::*;
#(
    parameter int                DATA_WIDTH     = 128,
    parameter int                ID_WIDTH       = 4,
    parameter int                AXI_ID_WIDTH   = 4,
    parameter int                AXI_ADDR_WIDTH = 32,
    parameter logic [ID_WIDTH-1:0] Source_ID    = {ID_WIDTH{1'b1}}
) (
    input  logic [AXI_ADDR_WIDTH-1:0] addr,
    input  logic [7:0]                len,
    input  logic [7:0]                seq,
    input  logic                      final_pkt,
    input  logic [AXI_ID_WIDTH-1:0]   axi_id,
    input  logic [2:0]                pkt_type,
    output logic [DATA_WIDTH:0]       flit
);
    localparam int LEN_LSB   = AXI_ADDR_WIDTH;
    localparam int SEQ_LSB   = LEN_LSB + LEN_W;
    localparam int FINAL_LSB = SEQ_LSB + SEQ_W;
    localparam int ID_LSB    = FINAL_LSB + FINAL_W;
    localparam int SRC_LSB   = ID_LSB + AXI_ID_WIDTH;
    localparam int DEST_LSB  = SRC_LSB + ID_WIDTH;
    localparam int TYPE_LSB  = DEST_LSB + ID_WIDTH;

    always_comb begin
        flit                              = '0;
        flit[DATA_WIDTH]                  = 1'b1;
        flit[AXI_ADDR_WIDTH-1:0]          = addr;
        flit[LEN_LSB +: LEN_W]            = len;
        flit[SEQ_LSB +: SEQ_W]            = seq;
        flit[FINAL_LSB]                   = final_pkt;
        flit[ID_LSB +: AXI_ID_WIDTH]      = axi_id;
        flit[SRC_LSB +: ID_WIDTH]         = Source_ID;
        // Destination node is encoded in the top address bits.
        flit[DEST_LSB +: ID_WIDTH]        = addr[AXI_ADDR_WIDTH-1 -: ID_WIDTH];
        flit[TYPE_LSB +: TYPE_W]          = pkt_type;
    end
endmodule

// File: rtl/nmu_axi2noc_packet.sv
// ---------------------------------------------------------------------------
// nmu_axi2noc_packet
// NoC master unit request packetizer. Acts as an AXI4 slave for AW/W/AR and
// emits NoC packets (head flit + data flits) through a single registered
// output slot with noc_ready backpressure. Write bursts longer than
// FLIT_NUM_MAX-1 beats are split into several packets (INCR addressing).
// Ports:
//   noc_clk, noc_rst   clock, synchronous active-high reset
//   s_axi (slave)      AW / W / AR channels
//   nocdata            DATA_WIDTH+1 flit, MSB = flit valid
//   m_is_head/tail     flit framing
//   noc_ready          NoC accepts the current flit
//   nmu_busy           FSM not idle or a flit is pending
//   proto_err          sticky wlast / awlen mismatch
// ---------------------------------------------------------------------------
module nmu_axi2noc_packet
    import nmu_pkg::*;
#(
    parameter int                  DATA_WIDTH     = 128,
    parameter int                  FLIT_NUM_MAX   = 16,
    parameter int                  ID_WIDTH       = 4,
    parameter int                  AXI_ID_WIDTH   = 4,
    parameter int                  AXI_ADDR_WIDTH = 32,
    parameter logic [ID_WIDTH-1:0] Source_ID      = {ID_WIDTH{1'b1}}
) (
    input  logic                  noc_clk,
    input  logic                  noc_rst,
    nmu_axi2noc_packet_if.slave   s_axi,
    output logic [DATA_WIDTH:0]   nocdata,
    output logic                  m_is_head,
    output logic                  m_is_tail,
    input  logic                  noc_ready,
    output logic                  nmu_busy,
    output logic                  proto_err
);
    localparam logic [8:0] CHUNK_MAX = 9'(FLIT_NUM_MAX - 1);
    // Byte distance between consecutive packets of one write burst.
    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_STEP =
        AXI_ADDR_WIDTH'((FLIT_NUM_MAX - 1) * DATA_WIDTH / 8);

    nmu_state_e                state;
    logic                      rr_prio;     // 1: AR wins a simultaneous request
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [AXI_ID_WIDTH-1:0]   id_q;
    logic [8:0]                beats_left;  // up to 256
    logic [8:0]                chunk_left;
    logic [7:0]                seq_q;

    logic out_vld, slot_free, grant_ar, grant_aw;
    logic ar_fire, aw_fire, w_fire;

    logic [AXI_ADDR_WIDTH-1:0] h_addr;
    logic [8:0]                h_beats, h_chunk;
    logic [7:0]                h_len, h_seq;
    logic                      h_final;
    logic [AXI_ID_WIDTH-1:0]   h_id;
    logic [2:0]                h_type;
    logic [DATA_WIDTH:0]       head_flit;

    assign out_vld   = nocdata[DATA_WIDTH];
    assign slot_free = !out_vld || noc_ready;

    assign grant_ar = s_axi.s_axi_arvalid && (!s_axi.s_axi_awvalid || rr_prio);
    assign grant_aw = s_axi.s_axi_awvalid && (!s_axi.s_axi_arvalid || !rr_prio);

    // Readies are gated by reset so no handshake completes during the reset
    // cycle; a request accepted then would otherwise be lost.
    assign s_axi.s_axi_arready = !noc_rst && (state == IDLE) && grant_ar && slot_free;
    assign s_axi.s_axi_awready = !noc_rst && (state == IDLE) && grant_aw && slot_free;
    assign s_axi.s_axi_wready  = !noc_rst && (state == W_DATA) && slot_free;

    assign ar_fire = s_axi.s_axi_arvalid && s_axi.s_axi_arready;
    assign aw_fire = s_axi.s_axi_awvalid && s_axi.s_axi_awready;
    assign w_fire  = s_axi.s_axi_wvalid  && s_axi.s_axi_wready;

    assign nmu_busy = (state != IDLE) || out_vld;

    // Head field selection: AR / AW in IDLE, follow-on write head otherwise.
    always_comb begin
        h_addr  = addr_q + ADDR_STEP;
        h_beats = beats_left;
        h_seq   = seq_q + 8'd1;
        h_id    = id_q;
        h_type  = TYPE_WR;
        if (state == IDLE) begin
            h_seq = 8'd0;
            if (grant_ar) begin
                h_addr = s_axi.s_axi_araddr;
                h_id   = s_axi.s_axi_arid;
                h_type = TYPE_RD_REQ;
            end else begin
                h_addr  = s_axi.s_axi_awaddr;
                h_id    = s_axi.s_axi_awid;
                h_beats = {1'b0, s_axi.s_axi_awlen} + 9'd1;
            end
        end
        h_chunk = (h_beats > CHUNK_MAX) ? CHUNK_MAX : h_beats;
        h_len   = 8'(h_chunk - 9'd1);
        h_final = (h_chunk == h_beats);
        if ((state == IDLE) && grant_ar) begin
            h_len   = s_axi.s_axi_arlen;
            h_final = 1'b1;
        end
    end

    nmu_head_build #(
        .DATA_WIDTH     (DATA_WIDTH),
        .ID_WIDTH       (ID_WIDTH),
        .AXI_ID_WIDTH   (AXI_ID_WIDTH),
        .AXI_ADDR_WIDTH (AXI_ADDR_WIDTH),
        .Source_ID      (Source_ID)
    ) u_head_build (
        .addr      (h_addr),
        .len       (h_len),
        .seq       (h_seq),
        .final_pkt (h_final),
        .axi_id    (h_id),
        .pkt_type  (h_type),
        .flit      (head_flit)
    );

    // FSM and output flit register.
    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            state      <= IDLE;
            rr_prio    <= 1'b1;
            nocdata    <= '0;
            m_is_head  <= 1'b0;
            m_is_tail  <= 1'b0;
            proto_err  <= 1'b0;
            addr_q     <= '0;
            id_q       <= '0;
            beats_left <= '0;
            chunk_left <= '0;
            seq_q      <= '0;
        end else begin
            // Flit drained and nothing new loaded: slot goes empty.
            if (slot_free) begin
                nocdata[DATA_WIDTH] <= 1'b0;
                m_is_head           <= 1'b0;
                m_is_tail           <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (ar_fire) begin
                        nocdata   <= head_flit;
                        m_is_head <= 1'b1;
                        m_is_tail <= 1'b1;
                        if (s_axi.s_axi_awvalid) rr_prio <= ~rr_prio;
                    end else if (aw_fire) begin
                        nocdata    <= head_flit;
                        m_is_head  <= 1'b1;
                        m_is_tail  <= 1'b0;
                        if (s_axi.s_axi_arvalid) rr_prio <= ~rr_prio;
                        addr_q     <= s_axi.s_axi_awaddr;
                        id_q       <= s_axi.s_axi_awid;
                        beats_left <= h_beats;
                        chunk_left <= h_chunk;
                        seq_q      <= 8'd0;
                        state      <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        nocdata    <= {1'b1, s_axi.s_axi_wdata};
                        m_is_head  <= 1'b0;
                        m_is_tail  <= (chunk_left == 9'd1);
                        chunk_left <= chunk_left - 9'd1;
                        beats_left <= beats_left - 9'd1;
                        // Beat count comes from awlen; wlast is only checked.
                        if (s_axi.s_axi_wlast != (beats_left == 9'd1)) proto_err <= 1'b1;
                        if (beats_left == 9'd1)      state <= IDLE;
                        else if (chunk_left == 9'd1) state <= W_HEAD;
                    end
                end
                W_HEAD: begin
                    if (slot_free) begin
                        nocdata    <= head_flit;
                        m_is_head  <= 1'b1;
                        m_is_tail  <= 1'b0;
                        addr_q     <= h_addr;
                        seq_q      <= h_seq;
                        chunk_left <= h_chunk;
                        state      <= W_DATA;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nmu_axi2noc_packet.sv
// ---------------------------------------------------------------------------
// tb_nmu_axi2noc_packet
// Scoreboard bench for nmu_axi2noc_packet: stimulus tasks push expected flits
// when a handshake is seen; a monitor pops and compares every flit the DUT
// transfers (valid & noc_ready).
// ---------------------------------------------------------------------------
module tb_nmu_axi2noc_packet;
    localparam int DW   = 128;
    localparam int FNM  = 16;
    localparam int IDW  = 4;
    localparam int AIDW = 4;
    localparam int AW   = 32;

    localparam logic [DW:0] H_AR  = {1'b1, 64'h0, 64'h47E5_0007_3000_0100};
    localparam logic [DW:0] H_AW1 = {1'b1, 64'h0, 64'h23E3_0003_1000_0000};

    typedef struct packed {
        logic [DW:0] d;
        logic        h;
        logic        t;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          noc_ready = 1'b1;
    logic [DW:0]   nocdata;
    logic          m_is_head, m_is_tail, nmu_busy, proto_err;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    nmu_axi2noc_packet_if #(.DATA_WIDTH(DW), .AXI_ID_WIDTH(AIDW), .AXI_ADDR_WIDTH(AW)) axi ();

    nmu_axi2noc_packet #(
        .DATA_WIDTH(DW), .FLIT_NUM_MAX(FNM), .ID_WIDTH(IDW),
        .AXI_ID_WIDTH(AIDW), .AXI_ADDR_WIDTH(AW), .Source_ID(4'hF)
    ) dut (
        .noc_clk   (clk),
        .noc_rst   (rst),
        .s_axi     (axi.slave),
        .nocdata   (nocdata),
        .m_is_head (m_is_head),
        .m_is_tail (m_is_tail),
        .noc_ready (noc_ready),
        .nmu_busy  (nmu_busy),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    task automatic check_flit(input string name, input logic [DW:0] act, input logic [DW:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: handshake timeout, got none expected one", name);
    endtask

    function automatic void push(input logic [DW:0] d, input logic h, input logic t);
        exp_t e;
        e.d = d;
        e.h = h;
        e.t = t;
        exp_q.push_back(e);
    endfunction

    // Head layout for the default parameters (src = F, dest = addr[31:28]).
    function automatic logic [DW:0] hdr(input logic [AW-1:0] a, input logic [7:0] len,
                                        input logic [7:0] seq, input logic fin,
                                        input logic [AIDW-1:0] id, input logic [2:0] typ);
        logic [DW:0] f;
        f = '0;
        f[DW] = 1'b1;
        f[63:0] = {typ, a[31:28], 4'hF, id, fin, seq, len, a};
        return f;
    endfunction

    // Monitor: every transferred flit is compared against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && nocdata[DW] && noc_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_flit: got %h expected none", nocdata);
                end else begin
                    e = exp_q.pop_front();
                    check_flit("flit_data", nocdata, e.d);
                    check_bit("flit_head", m_is_head, e.h);
                    check_bit("flit_tail", m_is_tail, e.t);
                end
            end
        end
    end

    task automatic ar_req(input logic [AW-1:0] a, input logic [AIDW-1:0] id,
                          input logic [7:0] len, input logic [DW:0] exp_flit);
        axi.s_axi_araddr  = a;
        axi.s_axi_arid    = id;
        axi.s_axi_arlen   = len;
        axi.s_axi_arvalid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (axi.s_axi_arready) begin
                push(exp_flit, 1'b1, 1'b1);
                @(posedge clk); #1;
                axi.s_axi_arvalid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        axi.s_axi_arvalid = 1'b0;
        timeout("ar_handshake");
    endtask

    task automatic aw_req(input logic [AW-1:0] a, input logic [AIDW-1:0] id,
                          input logic [7:0] len, input logic [DW:0] exp_flit);
        axi.s_axi_awaddr  = a;
        axi.s_axi_awid    = id;
        axi.s_axi_awlen   = len;
        axi.s_axi_awvalid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (axi.s_axi_awready) begin
                push(exp_flit, 1'b1, 1'b0);
                @(posedge clk); #1;
                axi.s_axi_awvalid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        axi.s_axi_awvalid = 1'b0;
        timeout("aw_handshake");
    endtask

    task automatic w_beat(input logic [DW-1:0] d, input logic last, input logic tail);
        axi.s_axi_wdata  = d;
        axi.s_axi_wlast  = last;
        axi.s_axi_wvalid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (axi.s_axi_wready) begin
                push({1'b1, d}, 1'b0, tail);
                @(posedge clk); #1;
                axi.s_axi_wvalid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        axi.s_axi_wvalid = 1'b0;
        timeout("w_handshake");
    endtask

    // Hold noc_ready low 3 cycles with a beat offered; output must freeze.
    task automatic stall3(input logic [DW-1:0] d);
        logic [DW:0] snap;
        logic        sh, st;
        axi.s_axi_wdata  = d;
        axi.s_axi_wlast  = 1'b0;
        axi.s_axi_wvalid = 1'b1;
        noc_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 0) begin
                snap = nocdata;
                sh   = m_is_head;
                st   = m_is_tail;
                check_bit("stall_valid", nocdata[DW], 1'b1);
            end else begin
                check_flit("stall_data_stable", nocdata, snap);
                check_bit("stall_head_stable", m_is_head, sh);
                check_bit("stall_tail_stable", m_is_tail, st);
            end
            check_bit("stall_wready", axi.s_axi_wready, 1'b0);
            @(posedge clk); #1;
        end
        noc_ready = 1'b1;
    endtask

    task automatic wr_burst(input logic [AW-1:0] a, input logic [AIDW-1:0] id, input int len,
                            input logic [DW:0] h0, input int bad_idx, input int stall_at,
                            input logic [31:0] tag);
        int beats, k, j, rem, chunk;
        beats = len + 1;
        aw_req(a, id, 8'(len), h0);
        for (int i = 0; i < beats; i++) begin
            k     = i / (FNM - 1);
            j     = i % (FNM - 1);
            rem   = beats - k * (FNM - 1);
            chunk = (rem > FNM - 1) ? FNM - 1 : rem;
            if (j == 0 && i > 0)
                push(hdr(a + AW'(k * 240), 8'(chunk - 1), 8'(k), chunk == rem, id, 3'b001), 1'b1, 1'b0);
            if (i == stall_at) stall3({tag, 96'(i)});
            w_beat({tag, 96'(i)}, (i == beats - 1) || (i == bad_idx), j == chunk - 1);
        end
    endtask

    initial begin
        axi.s_axi_awvalid = 1'b0; axi.s_axi_wvalid = 1'b0; axi.s_axi_arvalid = 1'b0;
        axi.s_axi_awid = '0; axi.s_axi_awaddr = '0; axi.s_axi_awlen = '0;
        axi.s_axi_wdata = '0; axi.s_axi_wlast = 1'b0;
        axi.s_axi_arid = '0; axi.s_axi_araddr = '0; axi.s_axi_arlen = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_flit("rst_nocdata", nocdata, '0);
        check_bit("rst_head", m_is_head, 1'b0);
        check_bit("rst_tail", m_is_tail, 1'b0);
        check_bit("rst_busy", nmu_busy, 1'b0);
        check_bit("rst_proto_err", proto_err, 1'b0);
        check_bit("rst_awready", axi.s_axi_awready, 1'b0);
        check_bit("rst_arready", axi.s_axi_arready, 1'b0);
        check_bit("rst_wready", axi.s_axi_wready, 1'b0);

        // Single read request: one head=tail flit, one cycle after handshake
        ar_req(32'h3000_0100, 4'd2, 8'd7, H_AR);
        check_flit("ar_latency_flit", nocdata, H_AR);
        check_bit("ar_latency_head", m_is_head, 1'b1);
        check_bit("ar_latency_tail", m_is_tail, 1'b1);
        repeat (2) @(posedge clk); #1;
        check_bit("ar_idle_busy", nmu_busy, 1'b0);

        // Short write: head + 4 data flits
        wr_burst(32'h1000_0000, 4'd1, 3, H_AW1, -1, -1, 32'hA1A1_0000);
        repeat (2) @(posedge clk); #1;
        check_bit("aw4_proto_err", proto_err, 1'b0);
        check_bit("aw4_idle_busy", nmu_busy, 1'b0);

        // Split write: 20 beats -> packets of 15 and 5
        wr_burst(32'h1000_0000, 4'd5, 19, hdr(32'h1000_0000, 8'd14, 8'd0, 1'b0, 4'd5, 3'b001),
                 -1, -1, 32'hB2B2_0000);
        // Same split with a stall while the second head is pending, and a
        // stall in the middle of a short packet
        wr_burst(32'h1000_0000, 4'd6, 19, hdr(32'h1000_0000, 8'd14, 8'd0, 1'b0, 4'd6, 3'b001),
                 -1, 15, 32'hC3C3_0000);
        wr_burst(32'h2000_0040, 4'd7, 3, hdr(32'h2000_0040, 8'd3, 8'd0, 1'b1, 4'd7, 3'b001),
                 -1, 2, 32'hD4D4_0000);
        repeat (2) @(posedge clk); #1;
        check_bit("stall_proto_err", proto_err, 1'b0);

        // Early wlast on beat 2: all 4 beats still sent, sticky error
        wr_burst(32'h4000_0000, 4'd3, 3, hdr(32'h4000_0000, 8'd3, 8'd0, 1'b1, 4'd3, 3'b001),
                 1, -1, 32'hE5E5_0000);
        repeat (2) @(posedge clk); #1;
        check_bit("wlast_proto_err", proto_err, 1'b1);
        ar_req(32'h5000_0000, 4'd1, 8'd0, hdr(32'h5000_0000, 8'd0, 8'd0, 1'b1, 4'd1, 3'b010));
        repeat (2) @(posedge clk); #1;
        check_bit("wlast_proto_err_sticky", proto_err, 1'b1);

        // Reset in the middle of a burst
        aw_req(32'h6000_0000, 4'd4, 8'd3, hdr(32'h6000_0000, 8'd3, 8'd0, 1'b1, 4'd4, 3'b001));
        w_beat({32'hF6F6_0000, 96'd0}, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        check_flit("midrst_nocdata", nocdata, '0);
        check_bit("midrst_head", m_is_head, 1'b0);
        check_bit("midrst_tail", m_is_tail, 1'b0);
        check_bit("midrst_busy", nmu_busy, 1'b0);
        check_bit("midrst_proto_err", proto_err, 1'b0);
        rst = 1'b0;
        exp_q.delete();
        axi.s_axi_wvalid = 1'b1;
        axi.s_axi_wlast  = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check_bit("midrst_wready_idle", axi.s_axi_wready, 1'b0);
            check_bit("midrst_no_flit", nocdata[DW], 1'b0);
        end
        @(posedge clk); #1;
        axi.s_axi_wvalid = 1'b0;

        // Simultaneous AR/AW after reset: AR first, then the next pair AW first
        fork
            ar_req(32'h3000_0200, 4'd9, 8'd1, hdr(32'h3000_0200, 8'd1, 8'd0, 1'b1, 4'd9, 3'b010));
            wr_burst(32'h7000_0000, 4'd8, 1, hdr(32'h7000_0000, 8'd1, 8'd0, 1'b1, 4'd8, 3'b001),
                     -1, -1, 32'h1717_0000);
        join
        repeat (2) @(posedge clk); #1;
        fork
            ar_req(32'h3000_0300, 4'd10, 8'd2, hdr(32'h3000_0300, 8'd2, 8'd0, 1'b1, 4'd10, 3'b010));
            wr_burst(32'h8000_0000, 4'd11, 2, hdr(32'h8000_0000, 8'd2, 8'd0, 1'b1, 4'd11, 3'b001),
                     -1, -1, 32'h2828_0000);
        join

        repeat (5) @(posedge clk); #1;
        check_int("scoreboard_drained", exp_q.size(), 0);
        check_bit("end_busy", nmu_busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/nmu_axi2noc_packet.md
Name: nmu_axi2noc_packet

Overview:
NoC master unit request packetizer, the initiator-side counterpart of the NoC slave unit. It acts as an AXI4 slave toward a user master, accepts AW/W and AR requests, and emits NoC packets (head flit plus data flits) into the NoC with noc_ready backpressure. Write bursts longer than one packet are split into several packets. The response path (B/R depacketizing) is a separate block.

Parameters:
DATA_WIDTH, 128, flit payload width; must be ≥ AXI_ADDR_WIDTH+2*ID_WIDTH+AXI_ID_WIDTH+20.
FLIT_NUM_MAX, 16, max flits per packet, head included; data flits per packet = FLIT_NUM_MAX-1.
ID_WIDTH, 4, NoC node id width.
AXI_ID_WIDTH, 4, AXI transaction id width.
AXI_ADDR_WIDTH, 32, AXI address width.
Source_ID, {ID_WIDTH{1'b1}}, this node's NoC id.

Ports:
noc_clk  in  1  clock
noc_rst  in  1  synchronous reset, active-high
s_axi_awid  in  AXI_ID_WIDTH  write id
s_axi_awaddr  in  AXI_ADDR_WIDTH  write address
s_axi_awlen  in  8  beats-1
s_axi_awvalid / s_axi_awready  in/out  1  AW handshake
s_axi_wdata  in  DATA_WIDTH  write data
s_axi_wlast  in  1  last beat marker, checked only
s_axi_wvalid / s_axi_wready  in/out  1  W handshake
s_axi_arid  in  AXI_ID_WIDTH  read id
s_axi_araddr  in  AXI_ADDR_WIDTH  read address
s_axi_arlen  in  8  beats-1
s_axi_arvalid / s_axi_arready  in/out  1  AR handshake
nocdata  out  DATA_WIDTH+1  flit; bit DATA_WIDTH is the flit-valid bit
m_is_head  out  1  current flit is a head
m_is_tail  out  1  current flit is a tail
noc_ready  in  1  NoC accepts the flit
nmu_busy  out  1  state != IDLE or output flit valid
proto_err  out  1  sticky wlast mismatch

Behaviour:
- Reset: nocdata, m_is_head, m_is_tail, all readies, nmu_busy and proto_err are 0. State is IDLE, rr_prio selects AR.
- Output register: nocdata, m_is_head and m_is_tail are registered. A flit transfers when nocdata[DATA_WIDTH] & noc_ready. While noc_ready=0 all three are held stable.
- slot_free = !nocdata[DATA_WIDTH] | noc_ready. When the slot is free and nothing new is loaded, the valid bit clears next cycle.
- Head flit fields, LSB first:
  - addr[AXI_ADDR_WIDTH]
  - len[8]
  - seq[8]
  - final[1]
  - axi_id[AXI_ID_WIDTH]
  - src=Source_ID[ID_WIDTH]
  - dest=addr[MSB -: ID_WIDTH]
  - type[3]: 3'b001 write, 3'b010 read request
  - remaining bits 0
- Data flit: {1'b1, wdata}.
- IDLE:
  - Grant goes to AR if only arvalid, AW if only awvalid; if both, rr_prio decides and rr_prio toggles on every grant.
  - arready / awready = IDLE & granted & slot_free. The head loads on the handshake edge, so latency is 1 cycle.
  - AR: single flit with head=tail=1, len=arlen, seq=0, final=1; remains IDLE.
  - AW: latch id, addr, beats_left=awlen+1, seq=0, chunk=min(beats_left, FLIT_NUM_MAX-1). Head len=chunk-1, final=(chunk==beats_left). Go to W_DATA.
- W_DATA:
  - wready = slot_free.
  - Each W handshake loads a data flit and decrements chunk_left and beats_left.
  - m_is_tail=1 when chunk_left==1.
  - Last beat of chunk with beats_left>1: go to W_HEAD. Last beat of burst: go to IDLE.
- W_HEAD:
  - When slot_free, emit the next head: addr += (FLIT_NUM_MAX-1)*DATA_WIDTH/8 (INCR only; awburst is not a port), seq+1, new chunk/len/final as above. Go to W_DATA.
- wlast check: the beat count comes solely from awlen. wlast=1 on a non-final beat, or wlast=0 on the final beat, sets proto_err (sticky until reset). All awlen+1 beats are still consumed.
- No AR is accepted during a write burst; packets never interleave.
- Address arithmetic wraps modulo 2^AXI_ADDR_WIDTH. seq is 8 bits and cannot overflow, since at most 256/(FLIT_NUM_MAX-1) packets are produced.
- noc_rst mid-burst: immediately returns to reset values and IDLE. The partial packet is dropped with no tail; this is system-level acceptable.

Decomposition:
- Shared package nmu_pkg: flit type codes (TYPE_WR=3'b001, TYPE_RD_REQ=3'b010), head-field offset/width constants, FSM state encoding (IDLE, W_DATA, W_HEAD).
- One sub-module, nmu_head_build: combinational head-flit formatter (fields in, DATA_WIDTH+1 flit out), reused by the AR, AW and W_HEAD paths.
- Output register and FSM stay in the top.

Test Plan:
- AR araddr=0x3000_0100, arid=2, arlen=7, noc_ready=1 → one flit one cycle later: head=tail=1, type=010, dest=3, len=7, seq=0, final=1; state IDLE.
- AW awaddr=0x1000_0000, awlen=3, 4 W beats, noc_ready=1 → 5 consecutive flits: head(len=3, final=1, dest=1), 4 data flits, tail on the 4th; wready high 4 cycles; proto_err=0.
- AW awlen=19, FLIT_NUM_MAX=16 → sequence:
  - head(addr 0x1000_0000, len=14, seq=0, final=0)
  - 15 data flits, tail on the 15th
  - head(addr 0x1000_00F0, len=4, seq=1, final=1)
  - 5 data flits, tail on the last
- noc_ready low 3 cycles mid-burst → nocdata/head/tail stable, wready=0, no beat lost or duplicated; the sequence resumes identically.
- awvalid & arvalid together after reset → AR head first, then the AW packet; next simultaneous pair → AW packet first.
- wlast on beat 2 of awlen=3 → proto_err=1 and stays 1, 4 beats still sent. noc_rst asserted mid-burst → next cycle all outputs 0, nmu_busy=0, IDLE.
